// File: rtl/mdl_pwm_stream_pkg.sv
// Shared definitions for the PWM stream block: modulus table, FSM states and lane derivation.
package pkg_bdy;

   localparam int QW = 24;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_A   = 2'd1,
      ST_STREAM_B = 2'd2,
      ST_DRAIN    = 2'd3
   } state_t;

   function automatic int f_lanes(input int daxi, input int dram);
      return daxi / dram;
   endfunction

   function automatic logic [QW-1:0] f_q(input logic [1:0] sel);
      logic [QW-1:0] q;
      case (sel)
         2'd0:    q = 24'd8380417;
         2'd1:    q = 24'd8383489;
         2'd2:    q = 24'd16760833;
         default: q = 24'd7340033;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/mdl_pwm_stream_modmul.sv
// One lane of (a*b) mod q: full-width product, reduction, then delay to PRM_LAT cycles total.
module mdl_modmul
   import pkg_bdy::*;
#(
   parameter int PRM_DRAM = 32,
   parameter int PRM_LAT  = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PRM_DRAM-1:0] i_a,
   input  logic [PRM_DRAM-1:0] i_b,
   input  logic [QW-1:0]       i_q,
   output logic [PRM_DRAM-1:0] o_res
);

   localparam int PW = 2 * PRM_DRAM;

   logic [PW-1:0] w_prod;
   logic [PW-1:0] w_q_ext;

   assign w_prod  = PW'(i_a) * PW'(i_b);
   assign w_q_ext = PW'(i_q);

   generate
      if (PRM_LAT == 1) begin : g_lat1
         logic [PRM_DRAM-1:0] r_res;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_res <= '0;
            else          r_res <= PRM_DRAM'(w_prod % w_q_ext);
         end
         assign o_res = r_res;
      end else begin : g_latn
         // Stage 0 registers the product, stage 1 the reduced value, the rest only delay.
         logic [PW-1:0]       r_prod;
         logic [PRM_DRAM-1:0] r_stage [PRM_LAT-1];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_prod <= '0;
               for (int k = 0; k < PRM_LAT-1; k++) r_stage[k] <= '0;
            end else begin
               r_prod     <= w_prod;
               r_stage[0] <= PRM_DRAM'(r_prod % w_q_ext);
               for (int k = 1; k < PRM_LAT-1; k++) r_stage[k] <= r_stage[k-1];
            end
         end
         assign o_res = r_stage[PRM_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/mdl_pwm_stream.sv
// Streams polynomial A into a buffer, then emits A[i]*B[i] mod Q per lane for each B beat.
// Optional PWM_ERR_CHECK_EN: flag TLAST disagreeing with the expected last beat on oCTL_ERR.
module mdl_pwm_stream
   import pkg_bdy::*;
#(
   parameter int PRM_DAXI   = 64,
   parameter int PRM_DRAM   = 32,
   parameter int PRM_COEFFS = 4096,
   parameter int PRM_LAT    = 4
) (
   input  logic                  iSYS_CLK,
   input  logic                  iSYS_RST,
   input  logic                  iCTL_START,
   input  logic [1:0]            iCTL_Q,
   output logic                  oCTL_BUSY,
   output logic                  oCTL_DONE,
   output logic                  oCTL_ERR,
   input  logic                  iS_AXIS_TVALID,
   output logic                  oS_AXIS_TREADY,
   input  logic [PRM_DAXI-1:0]   iS_AXIS_TDATA,
   input  logic [PRM_DAXI/8-1:0] iS_AXIS_TKEEP,
   input  logic                  iS_AXIS_TLAST,
   output logic                  oM_AXIS_TVALID,
   input  logic                  iM_AXIS_TREADY,
   output logic [PRM_DAXI-1:0]   oM_AXIS_TDATA,
   output logic [PRM_DAXI/8-1:0] oM_AXIS_TKEEP,
   output logic                  oM_AXIS_TLAST
);

   localparam int PRM_LANES = f_lanes(PRM_DAXI, PRM_DRAM);
   localparam int NB        = PRM_COEFFS / PRM_LANES;
   localparam int CW        = (NB > 1) ? $clog2(NB) : 1;
   localparam int FD        = PRM_LAT + 2;
   localparam int PTW       = $clog2(FD);
   localparam int FCW       = $clog2(FD + 1);
   localparam int KW        = PRM_DAXI / 8;

   state_t              r_state;
   logic                r_busy;
   logic [1:0]          r_qsel;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_next;
   logic                w_cnt_last;
   logic                w_room;
   logic                w_s_ready;
   logic                w_s_fire;
   logic                w_b_fire;
   logic [PRM_DAXI-1:0] r_abuf [NB];
   logic [PRM_DAXI-1:0] r_a_rd;
   logic [PRM_DAXI-1:0] w_res;
   logic [QW-1:0]       w_q;
   logic [PRM_LAT-1:0]  r_pv;
   logic [PRM_LAT-1:0]  r_pl;
   logic [FCW-1:0]      r_infl;
   logic [PRM_DAXI:0]   r_fifo [FD];
   logic [PTW-1:0]      r_wr_ptr;
   logic [PTW-1:0]      r_rd_ptr;
   logic [FCW-1:0]      r_count;
   logic                w_push;
   logic                w_m_valid;
   logic                w_m_fire;
   logic                w_m_last;
   logic [PRM_DAXI:0]   w_head;
   logic                r_out_en;
   logic                w_unused;
`ifdef PWM_ERR_CHECK_EN
   logic                r_err;
`endif

   assign w_cnt_last = (r_cnt == CW'(NB - 1));
   // Accept a B beat only if every in-flight result plus this one has a guaranteed FIFO slot.
   assign w_room     = (int'(r_count) + int'(r_infl)) < FD;
   assign w_s_ready  = (r_state == ST_LOAD_A) || ((r_state == ST_STREAM_B) && w_room);
   assign w_s_fire   = iS_AXIS_TVALID && w_s_ready;
   assign w_b_fire   = w_s_fire && (r_state == ST_STREAM_B);
   assign w_q        = f_q(r_qsel);

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_s_fire) w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
   end

   // Read address runs one beat ahead so A[i] is already registered when B beat i arrives.
   always_ff @(posedge iSYS_CLK) begin
      if (w_s_fire && (r_state == ST_LOAD_A)) r_abuf[r_cnt] <= iS_AXIS_TDATA;
      r_a_rd <= r_abuf[w_cnt_next];
   end

   genvar gi;
   generate
      for (gi = 0; gi < PRM_LANES; gi++) begin : g_lane
         mdl_modmul #(
            .PRM_DRAM (PRM_DRAM),
            .PRM_LAT  (PRM_LAT)
         ) u_modmul (
            .i_clk   (iSYS_CLK),
            .i_rst_n (iSYS_RST),
            .i_a     (r_a_rd[gi*PRM_DRAM +: PRM_DRAM]),
            .i_b     (iS_AXIS_TDATA[gi*PRM_DRAM +: PRM_DRAM]),
            .i_q     (w_q),
            .o_res   (w_res[gi*PRM_DRAM +: PRM_DRAM])
         );
      end
   endgenerate

   assign w_push = r_pv[PRM_LAT-1];

   always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
         r_pv   <= '0;
         r_pl   <= '0;
         r_infl <= '0;
      end else begin
         r_pv[0] <= w_b_fire;
         r_pl[0] <= w_b_fire && w_cnt_last;
         for (int k = 1; k < PRM_LAT; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pl[k] <= r_pl[k-1];
         end
         r_infl <= r_infl + FCW'(w_b_fire) - FCW'(w_push);
      end
   end

   always_ff @(posedge iSYS_CLK) begin
      if (w_push) r_fifo[r_wr_ptr] <= {r_pl[PRM_LAT-1], w_res};
   end

   assign w_m_valid = (r_count != '0);
   assign w_head    = r_fifo[r_rd_ptr];
   assign w_m_fire  = w_m_valid && iM_AXIS_TREADY;
   assign w_m_last  = w_m_fire && w_head[PRM_DAXI];

   always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_out_en <= 1'b0;
      end else begin
         r_out_en <= 1'b1;
         if (w_push)   r_wr_ptr <= (r_wr_ptr == PTW'(FD - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_m_fire) r_rd_ptr <= (r_rd_ptr == PTW'(FD - 1)) ? '0 : r_rd_ptr + 1'b1;
         r_count <= r_count + FCW'(w_push) - FCW'(w_m_fire);
      end
   end

   always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_qsel  <= 2'd0;
         r_cnt   <= '0;
`ifdef PWM_ERR_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_cnt <= w_cnt_next;
         case (r_state)
            ST_IDLE: begin
               if (iCTL_START) begin
                  r_state <= ST_LOAD_A;
                  r_busy  <= 1'b1;
                  r_qsel  <= iCTL_Q;
               end
            end
            ST_LOAD_A:   if (w_s_fire && w_cnt_last) r_state <= ST_STREAM_B;
            ST_STREAM_B: if (w_s_fire && w_cnt_last) r_state <= ST_DRAIN;
            ST_DRAIN: begin
               if (w_m_last) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
`ifdef PWM_ERR_CHECK_EN
         if ((r_state == ST_IDLE) && iCTL_START)             r_err <= 1'b0;
         else if (w_s_fire && (iS_AXIS_TLAST != w_cnt_last)) r_err <= 1'b1;
`endif
      end
   end

`ifdef PWM_ERR_CHECK_EN
   assign oCTL_ERR = r_err;
   assign w_unused = ^iS_AXIS_TKEEP;
`else
   assign oCTL_ERR = 1'b0;
   assign w_unused = ^{iS_AXIS_TKEEP, iS_AXIS_TLAST};
`endif

   assign oCTL_BUSY      = r_busy;
   assign oCTL_DONE      = (r_state == ST_DRAIN) && w_m_last;
   assign oS_AXIS_TREADY = w_s_ready;
   assign oM_AXIS_TVALID = w_m_valid;
   assign oM_AXIS_TDATA  = w_m_valid ? w_head[PRM_DAXI-1:0] : '0;
   assign oM_AXIS_TLAST  = w_m_valid && w_head[PRM_DAXI];
   assign oM_AXIS_TKEEP  = {KW{r_out_en}};

endmodule
